seq_gen_10110: RTL and testbench

- Serial pattern transmitter; the source end of the 10110 sequence-detection path.
- On a start request it emits a programmable number of copies of a fixed bit pattern, MSB first, one bit per clock.
- Copies are either back-to-back, separated by an idle gap, or overlapped (suffix/prefix sharing).
- Drives the serial in_data input of the 10110 detector in system-level and loopback tests.

---
 rtl/seq_gen_10110.sv | 133 +++++++++++++
 tb/tb_seq_gen_10110.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_gen_10110.sv
// seq_gen_10110: serial pattern transmitter.
// Emits repeat_cnt copies of PATTERN MSB first, one bit per clock, either
// back-to-back, separated by GAP idle cycles, or overlapped by OVL_LEN bits.
// Every output is a flop; nothing is decoded combinationally.
module seq_gen_10110 #(
    parameter int                 PAT_LEN  = 5,
    parameter logic [PAT_LEN-1:0] PATTERN  = 5'b10110,
    parameter int                 OVL_LEN  = 2,
    parameter int                 GAP      = 2,
    parameter logic               IDLE_BIT = 1'b0,
    parameter int                 CNT_W    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] repeat_cnt,
    input  logic             overlap,
    input  logic             abort,
    output logic             out_data,
    output logic             out_valid,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] copies_left,
    output logic [2:0]       state
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SEND = 3'd1;
    localparam logic [2:0] S_GAP  = 3'd2;
    localparam logic [2:0] S_DONE = 3'd3;

    localparam int IDX_W = $clog2(PAT_LEN);
    // Gap counter runs GAP-1 down to 0; keep at least one bit when GAP<=1.
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

    // First bit index of a fresh copy, and of a copy that shares its prefix
    // with the previous copy's suffix.
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PAT_LEN - 1);
    localparam logic [IDX_W-1:0] IDX_OVL = IDX_W'(PAT_LEN - 1 - OVL_LEN);
    localparam logic [GAP_W-1:0] GAP_TOP = GAP_W'((GAP > 0) ? GAP - 1 : 0);

    logic [IDX_W-1:0] idx;
    logic [GAP_W-1:0] gap_cnt;
    logic             ovl_q;

    // Transmit FSM; outputs are registered alongside the state they describe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            idx         <= '0;
            gap_cnt     <= '0;
            ovl_q       <= 1'b0;
            copies_left <= '0;
            out_data    <= IDLE_BIT;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            // Cancel wins over every other transition, but only mid-run.
            if (abort && (state == S_SEND || state == S_GAP)) begin
                state       <= S_IDLE;
                idx         <= '0;
                copies_left <= '0;
                out_data    <= IDLE_BIT;
                out_valid   <= 1'b0;
                busy        <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        // A zero count is not a run: stay idle.
                        if (start && repeat_cnt != '0) begin
                            state       <= S_SEND;
                            idx         <= IDX_TOP;
                            out_data    <= PATTERN[IDX_TOP];
                            out_valid   <= 1'b1;
                            busy        <= 1'b1;
                            copies_left <= repeat_cnt;
                            ovl_q       <= overlap;
                        end
                    end
                    S_SEND: begin
                        if (idx != '0) begin
                            idx      <= idx - 1'b1;
                            out_data <= PATTERN[idx - 1'b1];
                        end else if (copies_left > CNT_W'(1)) begin
                            copies_left <= copies_left - 1'b1;
                            if (ovl_q) begin
                                idx      <= IDX_OVL;
                                out_data <= PATTERN[IDX_OVL];
                            end else if (GAP > 0) begin
                                state     <= S_GAP;
                                gap_cnt   <= GAP_TOP;
                                out_data  <= IDLE_BIT;
                                out_valid <= 1'b0;
                            end else begin
                                idx      <= IDX_TOP;
                                out_data <= PATTERN[IDX_TOP];
                            end
                        end else begin
                            state       <= S_DONE;
                            copies_left <= '0;
                            out_data    <= IDLE_BIT;
                            out_valid   <= 1'b0;
                            done        <= 1'b1;
                        end
                    end
                    S_GAP: begin
                        if (gap_cnt == '0) begin
                            state     <= S_SEND;
                            idx       <= IDX_TOP;
                            out_data  <= PATTERN[IDX_TOP];
                            out_valid <= 1'b1;
                        end else begin
                            gap_cnt <= gap_cnt - 1'b1;
                        end
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state     <= S_IDLE;
                        out_data  <= IDLE_BIT;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seq_gen_10110.sv
// Directed bench for seq_gen_10110: bit streams, gaps, overlap, abort,
// async reset, ignored starts and a 10110 detector on the serial output.
module tb_seq_gen_10110;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] repeat_cnt;
    logic       overlap;
    logic       abort;
    logic       out_data;
    logic       out_valid;
    logic       busy;
    logic       done;
    logic [3:0] copies_left;
    logic [2:0] state;

    int checks = 0;
    int errs   = 0;
    int det_cnt;
    int det_cyc;
    int done_seen;
    logic [3:0] cl_obs [0:31];

    seq_gen_10110 dut (
        .clk        (clk),
        .reset      (rst_n),
        .start      (start),
        .repeat_cnt (repeat_cnt),
        .overlap    (overlap),
        .abort      (abort),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .busy       (busy),
        .done       (done),
        .copies_left(copies_left),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; land 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called in cycle 1 of a run. vbits/dbits are MSB = cycle 1.
    // Also runs a 10110 detector on the valid bits of the stream.
    task automatic run_stream(input string tag, input int len,
                              input logic [31:0] vbits, input logic [31:0] dbits);
        logic [4:0] sr;
        sr = '0;
        det_cnt = 0;
        det_cyc = 0;
        for (int i = 1; i <= len; i++) begin
            chk($sformatf("%s_valid_c%0d", tag, i), 32'(out_valid), 32'(vbits[len-i]));
            chk($sformatf("%s_data_c%0d", tag, i), 32'(out_data), 32'(dbits[len-i]));
            chk($sformatf("%s_busy_c%0d", tag, i), 32'(busy), 1);
            cl_obs[i] = copies_left;
            if (out_valid) begin
                sr = {sr[3:0], out_data};
                if (sr == 5'b10110) begin
                    det_cnt++;
                    det_cyc = i;
                end
            end
            step();
        end
        chk({tag, "_done_pulse"}, 32'(done), 1);
        chk({tag, "_done_state"}, 32'(state), 3);
        chk({tag, "_done_busy"}, 32'(busy), 1);
        chk({tag, "_done_valid"}, 32'(out_valid), 0);
        chk({tag, "_done_copies"}, 32'(copies_left), 0);
        step();
        chk({tag, "_end_done"}, 32'(done), 0);
        chk({tag, "_end_state"}, 32'(state), 0);
        chk({tag, "_end_busy"}, 32'(busy), 0);
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        repeat_cnt = 4'd0;
        overlap    = 1'b0;
        abort      = 1'b0;

        // Reset values, before any clock edge
        #2;
        chk("rst_state", 32'(state), 0);
        chk("rst_data", 32'(out_data), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_copies", 32'(copies_left), 0);
        step();
        rst_n = 1'b1;
        step();
        chk("idle_state", 32'(state), 0);

        // Single copy, with the loopback detector model
        start = 1'b1; repeat_cnt = 4'd1; overlap = 1'b0;
        step();
        start = 1'b0;
        chk("one_state_c1", 32'(state), 1);
        chk("one_copies_c1", 32'(copies_left), 1);
        run_stream("one", 5, 32'b11111, 32'b10110);
        chk("loop_det_cnt", 32'(det_cnt), 1);
        chk("loop_det_cyc", 32'(det_cyc), 5);

        // Three overlapped copies: 10110 110 110
        start = 1'b1; repeat_cnt = 4'd3; overlap = 1'b1;
        step();
        start = 1'b0;
        run_stream("ovl", 11, 32'b11111111111, 32'b10110110110);
        chk("ovl_cl_c1", 32'(cl_obs[1]), 3);
        chk("ovl_cl_c5", 32'(cl_obs[5]), 3);
        chk("ovl_cl_c6", 32'(cl_obs[6]), 2);
        chk("ovl_cl_c8", 32'(cl_obs[8]), 2);
        chk("ovl_cl_c9", 32'(cl_obs[9]), 1);
        chk("ovl_cl_c11", 32'(cl_obs[11]), 1);
        chk("ovl_det_cnt", 32'(det_cnt), 3);

        // Two copies with a 2-cycle gap; inputs change after the start edge
        start = 1'b1; repeat_cnt = 4'd2; overlap = 1'b0;
        step();
        start = 1'b0; repeat_cnt = 4'd7; overlap = 1'b1;
        chk("gap_state_c1", 32'(state), 1);
        run_stream("gap", 12, 32'b111110011111, 32'b101100010110);
        chk("gap_cl_c5", 32'(cl_obs[5]), 2);
        chk("gap_cl_c8", 32'(cl_obs[8]), 1);
        chk("gap_det_cnt", 32'(det_cnt), 2);

        // Abort on the third bit of the first copy
        start = 1'b1; repeat_cnt = 4'd2; overlap = 1'b0;
        step();
        start = 1'b0;
        step();
        step();
        chk("abort_bit3", 32'(out_data), 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_state", 32'(state), 0);
        chk("abort_valid", 32'(out_valid), 0);
        chk("abort_data", 32'(out_data), 0);
        chk("abort_copies", 32'(copies_left), 0);
        chk("abort_busy", 32'(busy), 0);
        done_seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (done !== 1'b0) done_seen++;
            step();
        end
        chk("abort_no_done", 32'(done_seen), 0);
        start = 1'b1; repeat_cnt = 4'd1;
        step();
        start = 1'b0;
        run_stream("post_abort", 5, 32'b11111, 32'b10110);

        // Async reset between clock edges mid-SEND
        start = 1'b1; repeat_cnt = 4'd2;
        step();
        start = 1'b0;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_state", 32'(state), 0);
        chk("arst_valid", 32'(out_valid), 0);
        chk("arst_data", 32'(out_data), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_copies", 32'(copies_left), 0);
        step();
        rst_n = 1'b1;
        step();
        chk("arst_no_done", 32'(done), 0);
        chk("arst_idle", 32'(state), 0);

        // start with a zero count is ignored
        start = 1'b1; repeat_cnt = 4'd0;
        step();
        start = 1'b0;
        chk("zero_state", 32'(state), 0);
        chk("zero_valid", 32'(out_valid), 0);
        step();
        chk("zero_busy", 32'(busy), 0);

        // start held through a run is ignored while busy, then a back-to-back
        // start in the first idle cycle after DONE begins a new run
        start = 1'b1; repeat_cnt = 4'd1;
        step();
        repeat_cnt = 4'd3;
        run_stream("busy_start", 5, 32'b11111, 32'b10110);
        repeat_cnt = 4'd1;
        step();
        start = 1'b0;
        chk("b2b_state_c1", 32'(state), 1);
        run_stream("b2b", 5, 32'b11111, 32'b10110);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
